// File: rtl/holy_axil_arbiter.sv
// holy_axil_arbiter
//
// Round-robin 2:1 AXI-Lite arbiter. The debug module SBA master (s0) and the
// HOLY CORE data master (s1) share one AXI-Lite path (m) into the peripheral
// crossbar. Read and write channels are arbitrated independently. Each channel
// allows one outstanding transaction, and its grant is held from the address
// handshake through the response handshake.
//
// Optional feature macro: HOLY_AXIL_ARB_WATCHDOG_EN
//   When defined, each channel has a watchdog. A transaction still open
//   TIMEOUT_CYCLES cycles after grant is answered locally with SLVERR. Any late
//   downstream response is then sunk before the channel can grant again.
//   When undefined, timeout_o is tied to 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s0_* / s1_*          AXI-Lite slave ports (requester 0 / requester 1)
//   m_*                  AXI-Lite master port toward the crossbar
//   wr_grant, rd_grant   one-hot channel owner, 0 when the channel is idle
//   timeout_o            one-cycle pulse when a watchdog fires

module holy_axil_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic [31:0] s0_awaddr,
    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    output logic [1:0]  s0_bresp,
    output logic        s0_bvalid,
    input  logic        s0_bready,
    input  logic [31:0] s0_araddr,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    // requester 1
    input  logic [31:0] s1_awaddr,
    input  logic        s1_awvalid,
    output logic        s1_awready,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    input  logic        s1_wvalid,
    output logic        s1_wready,
    output logic [1:0]  s1_bresp,
    output logic        s1_bvalid,
    input  logic        s1_bready,
    input  logic [31:0] s1_araddr,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    // shared downstream
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    // status
    output logic [1:0]  wr_grant,
    output logic [1:0]  rd_grant,
    output logic        timeout_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic      wr_owner_q, wr_owner_d, wr_last_q, wr_last_d;
    logic      rd_owner_q, rd_owner_d, rd_last_q, rd_last_d;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

    // Watchdog state seen by the FSMs; constant 0 when the watchdog is compiled out.
    logic      wr_err, wr_stale, rd_err, rd_stale;

    // Owner-side views of the requesters
    logic      own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
    logic        wr_aw_ready, wr_w_ready, wr_b_valid;
    logic [1:0]  wr_b_resp;
    logic        rd_ar_ready, rd_r_valid;
    logic [1:0]  rd_r_resp;
    logic [31:0] rd_r_data;

    assign own_awvalid = wr_owner_q ? s1_awvalid : s0_awvalid;
    assign own_wvalid  = wr_owner_q ? s1_wvalid  : s0_wvalid;
    assign own_bready  = wr_owner_q ? s1_bready  : s0_bready;
    assign own_arvalid = rd_owner_q ? s1_arvalid : s0_arvalid;
    assign own_rready  = rd_owner_q ? s1_rready  : s0_rready;

    // Payload passthrough; only qualified by the valids driven below.
    assign m_awaddr = wr_owner_q ? s1_awaddr : s0_awaddr;
    assign m_wdata  = wr_owner_q ? s1_wdata  : s0_wdata;
    assign m_wstrb  = wr_owner_q ? s1_wstrb  : s0_wstrb;
    assign m_araddr = rd_owner_q ? s1_araddr : s0_araddr;

    // -------------------------------------------------------------------------
    // Write channel
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_owner_q <= 1'b0;
            wr_last_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_owner_q <= wr_owner_d;
            wr_last_q  <= wr_last_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_owner_d  = wr_owner_q;
        wr_last_d   = wr_last_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = wr_stale;  // sink a late B after a watchdog timeout
        wr_aw_ready = 1'b0;
        wr_w_ready  = 1'b0;
        wr_b_valid  = 1'b0;
        wr_b_resp   = m_bresp;

        if (wr_err) begin
            // Local SLVERR toward the owner; downstream valids stay low.
            wr_b_valid = 1'b1;
            wr_b_resp  = 2'b10;
            if (own_bready) wr_state_d = W_IDLE;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (!wr_stale && (s0_awvalid || s1_awvalid)) begin
                        wr_owner_d = (s0_awvalid && s1_awvalid) ? ~wr_last_q : s1_awvalid;
                        wr_last_d  = wr_owner_d;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                        wr_state_d = W_ADDR;
                    end
                end
                W_ADDR: begin
                    m_awvalid   = own_awvalid & ~aw_done_q;
                    m_wvalid    = own_wvalid & ~w_done_q;
                    wr_aw_ready = m_awready & ~aw_done_q;
                    wr_w_ready  = m_wready & ~w_done_q;
                    aw_done_d   = aw_done_q | (m_awvalid & m_awready);
                    w_done_d    = w_done_q | (m_wvalid & m_wready);
                    // AW and W may finish in either order or together.
                    if (aw_done_d && w_done_d) wr_state_d = W_RESP;
                end
                W_RESP: begin
                    wr_b_valid = m_bvalid;
                    m_bready   = own_bready;
                    if (m_bvalid && own_bready) wr_state_d = W_IDLE;
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    assign wr_grant   = (wr_state_q == W_IDLE) ? 2'b00 : (wr_owner_q ? 2'b10 : 2'b01);
    assign s0_awready = wr_aw_ready & ~wr_owner_q;
    assign s1_awready = wr_aw_ready & wr_owner_q;
    assign s0_wready  = wr_w_ready & ~wr_owner_q;
    assign s1_wready  = wr_w_ready & wr_owner_q;
    assign s0_bvalid  = wr_b_valid & ~wr_owner_q;
    assign s1_bvalid  = wr_b_valid & wr_owner_q;
    assign s0_bresp   = wr_b_resp;
    assign s1_bresp   = wr_b_resp;

    // -------------------------------------------------------------------------
    // Read channel
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_owner_q <= 1'b0;
            rd_last_q  <= 1'b1;
        end else begin
            rd_state_q <= rd_state_d;
            rd_owner_q <= rd_owner_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_owner_d  = rd_owner_q;
        rd_last_d   = rd_last_q;
        m_arvalid   = 1'b0;
        m_rready    = rd_stale;  // sink a late R after a watchdog timeout
        rd_ar_ready = 1'b0;
        rd_r_valid  = 1'b0;
        rd_r_resp   = m_rresp;
        rd_r_data   = m_rdata;

        if (rd_err) begin
            rd_r_valid = 1'b1;
            rd_r_resp  = 2'b10;
            rd_r_data  = '0;
            if (own_rready) rd_state_d = R_IDLE;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (!rd_stale && (s0_arvalid || s1_arvalid)) begin
                        rd_owner_d = (s0_arvalid && s1_arvalid) ? ~rd_last_q : s1_arvalid;
                        rd_last_d  = rd_owner_d;
                        rd_state_d = R_ADDR;
                    end
                end
                R_ADDR: begin
                    m_arvalid   = own_arvalid;
                    rd_ar_ready = m_arready;
                    if (own_arvalid && m_arready) rd_state_d = R_DATA;
                end
                R_DATA: begin
                    rd_r_valid = m_rvalid;
                    m_rready   = own_rready;
                    if (m_rvalid && own_rready) rd_state_d = R_IDLE;
                end
                default: rd_state_d = R_IDLE;
            endcase
        end
    end

    assign rd_grant   = (rd_state_q == R_IDLE) ? 2'b00 : (rd_owner_q ? 2'b10 : 2'b01);
    assign s0_arready = rd_ar_ready & ~rd_owner_q;
    assign s1_arready = rd_ar_ready & rd_owner_q;
    assign s0_rvalid  = rd_r_valid & ~rd_owner_q;
    assign s1_rvalid  = rd_r_valid & rd_owner_q;
    assign s0_rresp   = rd_r_resp;
    assign s1_rresp   = rd_r_resp;
    assign s0_rdata   = rd_r_data;
    assign s1_rdata   = rd_r_data;

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef HOLY_AXIL_ARB_WATCHDOG_EN
    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] wr_cnt_q, rd_cnt_q;
    logic            wr_err_q, wr_stale_q, rd_err_q, rd_stale_q, timeout_q;
    logic            wr_fire, rd_fire;

    // Fire on the last cycle of the budget unless the real response completes now.
    assign wr_fire = (wr_state_q != W_IDLE) && !wr_err_q && (wr_cnt_q == CntMax) &&
                     !((wr_state_q == W_RESP) && m_bvalid && own_bready);
    assign rd_fire = (rd_state_q != R_IDLE) && !rd_err_q && (rd_cnt_q == CntMax) &&
                     !((rd_state_q == R_DATA) && m_rvalid && own_rready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_stale_q <= 1'b0;
            rd_stale_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= wr_fire | rd_fire;

            if (wr_state_q == W_IDLE)  wr_cnt_q <= '0;
            else if (wr_cnt_q != CntMax) wr_cnt_q <= wr_cnt_q + CntW'(1);
            if (rd_state_q == R_IDLE)  rd_cnt_q <= '0;
            else if (rd_cnt_q != CntMax) rd_cnt_q <= rd_cnt_q + CntW'(1);

            if (wr_fire)                      wr_err_q <= 1'b1;
            else if (wr_state_d == W_IDLE)    wr_err_q <= 1'b0;
            if (rd_fire)                      rd_err_q <= 1'b1;
            else if (rd_state_d == R_IDLE)    rd_err_q <= 1'b0;

            // A late response can only come if the request fully reached the slave.
            if (wr_fire && (wr_state_q == W_RESP)) wr_stale_q <= 1'b1;
            else if (wr_stale_q && m_bvalid)       wr_stale_q <= 1'b0;
            if (rd_fire && (rd_state_q == R_DATA)) rd_stale_q <= 1'b1;
            else if (rd_stale_q && m_rvalid)       rd_stale_q <= 1'b0;
        end
    end

    assign wr_err    = wr_err_q;
    assign wr_stale  = wr_stale_q;
    assign rd_err    = rd_err_q;
    assign rd_stale  = rd_stale_q;
    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;

    assign wr_err    = 1'b0;
    assign wr_stale  = 1'b0;
    assign rd_err    = 1'b0;
    assign rd_stale  = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_holy_axil_arbiter.sv
// Directed self-checking bench for holy_axil_arbiter.
// Inputs change just after the falling edge; outputs are checked 1 ns later.

module tb_holy_axil_arbiter;

    logic        clk, rst_n;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [1:0]  s0_bresp, s0_rresp;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [1:0]  s1_bresp, s1_rresp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [1:0]  wr_grant, rd_grant;
    logic        timeout_o;

    int tests = 0;
    int fails = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0;
    int aw0, w0, b0;

    holy_axil_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream handshake counters (duplication check)
    always @(posedge clk) begin
        if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
        if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
        if (m_bvalid && m_bready)   b_hs  <= b_hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        s0_awaddr = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0;
        s0_bready = 0; s0_araddr = '0; s0_arvalid = 0; s0_rready = 0;
        s1_awaddr = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0;
        s1_bready = 0; s1_araddr = '0; s1_arvalid = 0; s1_rready = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;

        // ---- reset state
        #1;
        chk("rst_wr_grant", wr_grant, 0);
        chk("rst_rd_grant", rd_grant, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_bready", m_bready, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_timeout", timeout_o, 0);
        tick();
        rst_n = 1'b1;

        // ---- A: master 1 single write, B after 3 cycles
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        s1_awaddr = 32'h4000_0000; s1_awvalid = 1; s1_wdata = 32'hDEAD_BEEF;
        s1_wstrb = 4'hF; s1_wvalid = 1;
        #1 chk("a_idle_grant", wr_grant, 0);
        chk("a_idle_awvalid", m_awvalid, 0);
        tick();
        #1 chk("a_grant", wr_grant, 2'b10);
        chk("a_m_awvalid", m_awvalid, 1);
        chk("a_m_awaddr", m_awaddr, 32'h4000_0000);
        chk("a_m_wvalid", m_wvalid, 1);
        chk("a_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("a_m_wstrb", m_wstrb, 4'hF);
        chk("a_awready_wait", s1_awready, 0);
        m_awready = 1; m_wready = 1;
        #1 chk("a_s1_awready", s1_awready, 1);
        chk("a_s1_wready", s1_wready, 1);
        chk("a_s0_awready", s0_awready, 0);
        chk("a_s0_wready", s0_wready, 0);
        chk("a_timeout", timeout_o, 0);
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0; s1_bready = 1;
        #1 chk("a_resp_awvalid", m_awvalid, 0);
        chk("a_resp_grant", wr_grant, 2'b10);
        chk("a_resp_bvalid_early", s1_bvalid, 0);
        tick(); tick();
        m_bvalid = 1; m_bresp = 2'b00;
        #1 chk("a_s1_bvalid", s1_bvalid, 1);
        chk("a_s1_bresp", s1_bresp, 0);
        chk("a_s0_bvalid", s0_bvalid, 0);
        chk("a_m_bready", m_bready, 1);
        tick();
        m_bvalid = 0; s1_bready = 0;
        #1 chk("a_idle_after_b", wr_grant, 0);
        chk("a_aw_count", aw_hs - aw0, 1);
        chk("a_w_count", w_hs - w0, 1);
        chk("a_b_count", b_hs - b0, 1);

        // ---- B: simultaneous reads, master 0 first, one idle cycle, then master 1
        s0_araddr = 32'h1000_0000; s0_arvalid = 1;
        s1_araddr = 32'h2000_0000; s1_arvalid = 1;
        s0_rready = 1; s1_rready = 1;
        tick();
        #1 chk("b_grant_first", rd_grant, 2'b01);
        chk("b_m_araddr0", m_araddr, 32'h1000_0000);
        m_arready = 1;
        #1 chk("b_s0_arready", s0_arready, 1);
        chk("b_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h1111_2222; m_rresp = 2'b00;
        #1 chk("b_arvalid_done", m_arvalid, 0);
        chk("b_s0_rvalid", s0_rvalid, 1);
        chk("b_s0_rdata", s0_rdata, 32'h1111_2222);
        chk("b_s1_rvalid", s1_rvalid, 0);
        tick();
        m_rvalid = 0;
        #1 chk("b_idle_gap", rd_grant, 2'b00);
        chk("b_idle_arvalid", m_arvalid, 0);
        tick();
        #1 chk("b_grant_second", rd_grant, 2'b10);
        chk("b_m_araddr1", m_araddr, 32'h2000_0000);
        m_arready = 1;
        tick();
        s1_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h3333_4444;
        #1 chk("b_s1_rvalid", s1_rvalid, 1);
        chk("b_s1_rdata", s1_rdata, 32'h3333_4444);
        chk("b_s0_rvalid_off", s0_rvalid, 0);
        tick();
        m_rvalid = 0;
        #1 chk("b_end_idle", rd_grant, 0);

        // ---- C: concurrent read (master 0) and write (master 1)
        s0_araddr = 32'h3000_0800; s0_arvalid = 1;
        s1_awaddr = 32'h8000_0004; s1_awvalid = 1;
        s1_wdata = 32'h1234_5678; s1_wstrb = 4'h3; s1_wvalid = 1;
        tick();
        #1 chk("c_rd_grant", rd_grant, 2'b01);
        chk("c_wr_grant", wr_grant, 2'b10);
        chk("c_m_araddr", m_araddr, 32'h3000_0800);
        chk("c_m_awaddr", m_awaddr, 32'h8000_0004);
        m_arready = 1; m_awready = 1; m_wready = 1;
        #1 chk("c_s0_arready", s0_arready, 1);
        chk("c_s1_arready", s1_arready, 0);
        chk("c_s1_awready", s1_awready, 1);
        chk("c_s0_awready", s0_awready, 0);
        chk("c_s0_wready", s0_wready, 0);
        tick();
        s0_arvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
        m_arready = 0; m_awready = 0; m_wready = 0;
        s0_bready = 1; s1_bready = 1;
        m_rvalid = 1; m_rdata = 32'hCAFE_F00D; m_bvalid = 1; m_bresp = 2'b00;
        #1 chk("c_s0_rvalid", s0_rvalid, 1);
        chk("c_s1_rvalid", s1_rvalid, 0);
        chk("c_s1_bvalid", s1_bvalid, 1);
        chk("c_s0_bvalid", s0_bvalid, 0);
        chk("c_s0_rdata", s0_rdata, 32'hCAFE_F00D);
        tick();
        m_rvalid = 0; m_bvalid = 0;
        #1 chk("c_wr_idle", wr_grant, 0);
        chk("c_rd_idle", rd_grant, 0);

        // ---- D1: W two cycles ahead of AW (master 0)
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        s0_wdata = 32'hA5A5_0001; s0_wstrb = 4'hF; s0_wvalid = 1;
        tick();
        #1 chk("d1_w_only_no_grant", wr_grant, 0);
        chk("d1_w_only_wvalid", m_wvalid, 0);
        tick();
        s0_awaddr = 32'h5000_0010; s0_awvalid = 1;
        tick();
        #1 chk("d1_grant", wr_grant, 2'b01);
        m_wready = 1;
        #1 chk("d1_s0_wready", s0_wready, 1);
        chk("d1_s0_awready", s0_awready, 0);
        tick();
        s0_wvalid = 0; m_wready = 0;
        #1 chk("d1_wvalid_done", m_wvalid, 0);
        chk("d1_awvalid_held", m_awvalid, 1);
        m_awready = 1;
        tick();
        s0_awvalid = 0; m_awready = 0; m_bvalid = 1;
        #1 chk("d1_awvalid_done", m_awvalid, 0);
        chk("d1_s0_bvalid", s0_bvalid, 1);
        tick();
        m_bvalid = 0;
        #1 chk("d1_idle", wr_grant, 0);
        chk("d1_aw_count", aw_hs - aw0, 1);
        chk("d1_w_count", w_hs - w0, 1);
        chk("d1_b_count", b_hs - b0, 1);

        // ---- D2: AW two cycles ahead of W (master 0)
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        s0_awaddr = 32'h5000_0020; s0_awvalid = 1;
        tick();
        #1 chk("d2_grant", wr_grant, 2'b01);
        chk("d2_wvalid_absent", m_wvalid, 0);
        m_awready = 1;
        tick();
        s0_awvalid = 0; m_awready = 0;
        #1 chk("d2_awvalid_done", m_awvalid, 0);
        chk("d2_still_addr_bvalid", s0_bvalid, 0);
        tick();
        s0_wdata = 32'hA5A5_0002; s0_wvalid = 1; m_wready = 1;
        #1 chk("d2_s0_wready", s0_wready, 1);
        chk("d2_awvalid_stays_low", m_awvalid, 0);
        tick();
        s0_wvalid = 0; m_wready = 0; m_bvalid = 1;
        #1 chk("d2_s0_bvalid", s0_bvalid, 1);
        tick();
        m_bvalid = 0; s0_bready = 0; s1_bready = 0;
        #1 chk("d2_idle", wr_grant, 0);
        chk("d2_aw_count", aw_hs - aw0, 1);
        chk("d2_w_count", w_hs - w0, 1);
        chk("d2_b_count", b_hs - b0, 1);

`ifdef HOLY_AXIL_ARB_WATCHDOG_EN
        // ---- E: read hang with TIMEOUT_CYCLES = 16, late R at cycle 30
        s0_rready = 0; s1_rready = 0;
        s0_araddr = 32'h6000_0000; s0_arvalid = 1;
        tick();                               // grant edge G
        #1 chk("e_grant", rd_grant, 2'b01);
        m_arready = 1;
        tick();                               // G+1: AR accepted
        s0_arvalid = 0; m_arready = 0; m_rdata = 32'hBAD0_BAD0; m_rresp = 2'b00;
        repeat (14) tick();                   // G+15
        #1 chk("e_no_resp_yet", s0_rvalid, 0);
        chk("e_no_timeout_yet", timeout_o, 0);
        tick();                               // G+16
        #1 chk("e_err_rvalid", s0_rvalid, 1);
        chk("e_err_rresp", s0_rresp, 2'b10);
        chk("e_err_rdata", s0_rdata, 0);
        chk("e_timeout_pulse", timeout_o, 1);
        chk("e_arvalid_low", m_arvalid, 0);
        chk("e_sink_rready", m_rready, 1);
        tick();                               // G+17
        #1 chk("e_timeout_single", timeout_o, 0);
        chk("e_err_held", s0_rvalid, 1);
        s0_rready = 1;
        tick();                               // G+18: back to idle, channel stale
        s0_araddr = 32'h6000_0004; s0_arvalid = 1;
        for (int i = 0; i < 12; i++) begin
            #1 chk("e_blocked_while_stale", rd_grant, 0);
            tick();
        end                                   // G+30
        m_rvalid = 1; m_rdata = 32'h0000_0055;
        #1 chk("e_late_sink_rready", m_rready, 1);
        chk("e_late_not_forwarded", s0_rvalid, 0);
        tick();                               // G+31: stale cleared
        m_rvalid = 0;
        #1 chk("e_no_grant_on_sink", rd_grant, 0);
        tick();                               // G+32: new grant
        #1 chk("e_regrant", rd_grant, 2'b01);
        chk("e_regrant_araddr", m_araddr, 32'h6000_0004);
        m_arready = 1;
        tick();
        s0_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h0000_ABCD;
        #1 chk("e_ok_rvalid", s0_rvalid, 1);
        chk("e_ok_rresp", s0_rresp, 0);
        chk("e_ok_rdata", s0_rdata, 32'h0000_ABCD);
        tick();
        m_rvalid = 0; s0_rready = 0;
`endif

        // ---- F: reset during W_RESP, then a fresh write pair
        s1_awaddr = 32'h7000_0000; s1_awvalid = 1; s1_wdata = 32'h0BAD_CAFE; s1_wvalid = 1;
        tick();
        m_awready = 1; m_wready = 1;
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; s1_bready = 0;
        #1 chk("f_resp_bvalid", s1_bvalid, 1);
        chk("f_resp_grant", wr_grant, 2'b10);
        #1 rst_n = 0;
        #1 chk("f_rst_grant", wr_grant, 0);
        chk("f_rst_bvalid", s1_bvalid, 0);
        chk("f_rst_bready", m_bready, 0);
        chk("f_rst_timeout", timeout_o, 0);
        m_bvalid = 0;
        tick();
        rst_n = 1;
        // Tie right after reset: master 0 wins
        s0_awaddr = 32'h7000_0100; s0_awvalid = 1; s0_wdata = 32'h1; s0_wvalid = 1;
        s1_awaddr = 32'h7000_0200; s1_awvalid = 1; s1_wdata = 32'h2; s1_wvalid = 1;
        #1 chk("f_idle_after_rst", wr_grant, 0);
        tick();
        #1 chk("f_tie_grant", wr_grant, 2'b01);
        chk("f_tie_awaddr", m_awaddr, 32'h7000_0100);
        m_awready = 1; m_wready = 1;
        tick();
        s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
        s0_bready = 1; m_bvalid = 1; m_bresp = 2'b00;
        #1 chk("f_s0_bvalid", s0_bvalid, 1);
        chk("f_s1_bvalid", s1_bvalid, 0);
        tick();
        m_bvalid = 0;
        #1 chk("f_gap", wr_grant, 0);
        tick();
        #1 chk("f_next_grant", wr_grant, 2'b10);
        chk("f_next_awaddr", m_awaddr, 32'h7000_0200);
        s1_awvalid = 0; s1_wvalid = 0; s0_bready = 0;

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
